// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - parametrised synchronous FIFO with thresholds and sticky errors
// Inputs : clk, reset (async, active-low), en, wr, rd, err_clr, data_in,
//          umbral_alto (almost-full level), umbral_bajo (almost-empty level)
// Outputs: data_out/valid_out (registered read data + strobe), outFull, outEmpty,
//          almostFull, almostEmpty, fifo_count, errorFull, errorEmpty (sticky)
module fifo_umbral #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3,
  parameter int BUFFER_DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     wr,
  input  logic                     rd,
  input  logic                     err_clr,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [ADDRESS_WIDTH:0]   umbral_alto,
  input  logic [ADDRESS_WIDTH:0]   umbral_bajo,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid_out,
  output logic                     outFull,
  output logic                     outEmpty,
  output logic                     almostFull,
  output logic                     almostEmpty,
  output logic [ADDRESS_WIDTH:0]   fifo_count,
  output logic                     errorFull,
  output logic                     errorEmpty
);

  localparam logic [ADDRESS_WIDTH:0]   DEPTH_C = (ADDRESS_WIDTH+1)'(BUFFER_DEPTH);
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE = (ADDRESS_WIDTH+1)'(1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = ADDRESS_WIDTH'(1);

  logic [DATA_WIDTH-1:0]    r_mem [BUFFER_DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
  logic [ADDRESS_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0]    r_data_out;
  logic                     r_valid;
  logic                     r_err_full;
  logic                     r_err_empty;

  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_set_ef;
  logic w_set_ee;

  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_rd_acc = en & rd & ~w_empty;
  // A read on the same edge frees a slot, so a full FIFO still takes the write.
  assign w_wr_acc = en & wr & (~w_full | rd);
  assign w_set_ef = en & wr & w_full & ~rd;
  assign w_set_ee = en & rd & w_empty;

  // Storage is not reset; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_err_full  <= 1'b0;
      r_err_empty <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_data_out <= r_mem[r_rd_ptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // Freeze (en=0) also holds the error flags; a new error beats a clear.
      if (en) begin
        if (w_set_ef) begin
          r_err_full <= 1'b1;
        end else if (err_clr) begin
          r_err_full <= 1'b0;
        end
        if (w_set_ee) begin
          r_err_empty <= 1'b1;
        end else if (err_clr) begin
          r_err_empty <= 1'b0;
        end
      end
    end
  end

  assign data_out    = r_data_out;
  assign valid_out   = r_valid;
  assign fifo_count  = r_count;
  assign outFull     = w_full;
  assign outEmpty    = w_empty;
  assign almostFull  = (r_count >= umbral_alto);
  assign almostEmpty = (r_count <= umbral_bajo);
  assign errorFull   = r_err_full;
  assign errorEmpty  = r_err_empty;

endmodule

// File: tb/tb_fifo_umbral.sv
// tb/tb_fifo_umbral.sv - bench for fifo_umbral against a queue-based reference model
module tb_fifo_umbral;

  logic       clk;
  logic       reset;
  logic       en;
  logic       wr;
  logic       rd;
  logic       err_clr;
  logic [7:0] data_in;
  logic [3:0] umbral_alto;
  logic [3:0] umbral_bajo;
  logic [7:0] data_out;
  logic       valid_out;
  logic       outFull;
  logic       outEmpty;
  logic       almostFull;
  logic       almostEmpty;
  logic [3:0] fifo_count;
  logic       errorFull;
  logic       errorEmpty;

  fifo_umbral #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3), .BUFFER_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .en(en), .wr(wr), .rd(rd), .err_clr(err_clr),
    .data_in(data_in), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .data_out(data_out), .valid_out(valid_out), .outFull(outFull), .outEmpty(outEmpty),
    .almostFull(almostFull), .almostEmpty(almostEmpty), .fifo_count(fifo_count),
    .errorFull(errorFull), .errorEmpty(errorEmpty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus the visible registered outputs.
  logic [7:0] m_q[$];
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_ef;
  logic       m_ee;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout  = 8'h00;
    m_valid = 1'b0;
    m_ef    = 1'b0;
    m_ee    = 1'b0;
  endtask

  // Applies the FIFO rules for one clock edge using the inputs that were presented.
  task automatic model_step();
    bit full;
    bit empty;
    full  = (m_q.size() == 8);
    empty = (m_q.size() == 0);
    if (!en) begin
      m_valid = 1'b0;
    end else begin
      if (rd && !empty) begin
        m_dout  = m_q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (wr && (!full || rd)) m_q.push_back(data_in);
      if (wr && full && !rd) m_ef = 1'b1;
      else if (err_clr)      m_ef = 1'b0;
      if (rd && empty)       m_ee = 1'b1;
      else if (err_clr)      m_ee = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = m_q.size();
    chk({tag, ".data_out"},    data_out,    m_dout);
    chk({tag, ".valid_out"},   valid_out,   m_valid);
    chk({tag, ".fifo_count"},  fifo_count,  n);
    chk({tag, ".outFull"},     outFull,     n == 8);
    chk({tag, ".outEmpty"},    outEmpty,    n == 0);
    chk({tag, ".almostFull"},  almostFull,  n >= int'(umbral_alto));
    chk({tag, ".almostEmpty"}, almostEmpty, n <= int'(umbral_bajo));
    chk({tag, ".errorFull"},   errorFull,   m_ef);
    chk({tag, ".errorEmpty"},  errorEmpty,  m_ee);
  endtask

  // One clock: present inputs, take the edge, advance the model, sample 1 time unit later.
  task automatic cyc(input string tag, input logic i_en, input logic i_wr, input logic i_rd,
                     input logic i_clr, input logic [7:0] i_din);
    en = i_en; wr = i_wr; rd = i_rd; err_clr = i_clr; data_in = i_din;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; data_in = 8'h00;
    umbral_alto = 4'd6; umbral_bajo = 4'd2;
    model_reset();

    // 1: reset state
    #12;
    check_all("t1_rst");
    reset = 1'b1;
    cyc("t1_idle", 1, 0, 0, 0, 8'h00);
    chk("t1_empty", outEmpty, 1);
    chk("t1_count", fifo_count, 0);

    // 2: fill, overflow attempt, drain in order
    for (int k = 1; k <= 8; k++) cyc("t2_wr", 1, 1, 0, 0, 8'(k * 8'h11));
    chk("t2_count8", fifo_count, 8);
    chk("t2_full", outFull, 1);
    cyc("t2_ovf", 1, 1, 0, 0, 8'h99);
    chk("t2_errfull", errorFull, 1);
    chk("t2_count_hold", fifo_count, 8);
    for (int k = 1; k <= 8; k++) begin
      cyc("t2_rd", 1, 0, 1, 0, 8'h00);
      chk("t2_dout", data_out, 8'(k * 8'h11));
      chk("t2_valid", valid_out, 1);
    end
    chk("t2_empty", outEmpty, 1);

    // 3: full with simultaneous read+write, then drain across the pointer wrap
    for (int k = 1; k <= 8; k++) cyc("t3_fill", 1, 1, 0, 0, 8'(k * 8'h11));
    for (int k = 0; k < 4; k++) cyc("t3_rw", 1, 1, 1, 0, 8'(8'hA0 + k));
    chk("t3_count8", fifo_count, 8);
    for (int k = 0; k < 8; k++) begin
      cyc("t3_drain", 1, 0, 1, 0, 8'h00);
      chk("t3_dout", data_out, (k < 4) ? 8'(8'h55 + k * 8'h11) : 8'(8'hA0 + k - 4));
    end

    // 4: underflow sets errorEmpty, err_clr clears both sticky flags
    cyc("t4_udf", 1, 0, 1, 0, 8'h00);
    chk("t4_errempty", errorEmpty, 1);
    chk("t4_novalid", valid_out, 0);
    cyc("t4_clr", 1, 0, 0, 1, 8'h00);
    chk("t4_cleared", errorEmpty, 0);
    // empty + rd&wr: write taken, read rejected with error, no fall-through
    cyc("t4_rw_empty", 1, 1, 1, 0, 8'h3C);
    chk("t4_rw_count", fifo_count, 1);
    chk("t4_rw_valid", valid_out, 0);
    cyc("t4_rd", 1, 0, 1, 1, 8'h00);
    chk("t4_rd_dout", data_out, 8'h3C);

    // 5: thresholds 6/2 going up then down
    umbral_alto = 4'd6; umbral_bajo = 4'd2;
    for (int k = 1; k <= 8; k++) begin
      cyc("t5_up", 1, 1, 0, 0, 8'($urandom));
      chk("t5_up_ae", almostEmpty, k <= 2);
      chk("t5_up_af", almostFull, k >= 6);
    end
    for (int k = 7; k >= 0; k--) begin
      cyc("t5_dn", 1, 0, 1, 0, 8'h00);
      chk("t5_dn_ae", almostEmpty, k <= 2);
      chk("t5_dn_af", almostFull, k >= 6);
    end

    // 6: asynchronous reset mid-operation, then freeze
    for (int k = 0; k < 5; k++) cyc("t6_wr", 1, 1, 0, 0, 8'(8'hC0 + k));
    cyc("t6_ovrd", 1, 0, 1, 0, 8'h00);
    reset = 1'b0;
    #1;
    model_reset();
    check_all("t6_async_rst");
    #2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) cyc("t6_wr2", 1, 1, 0, 0, 8'(8'hD0 + k));
    cyc("t6_rd", 1, 0, 1, 0, 8'h00);
    cyc("t6_freeze", 0, 1, 1, 1, 8'hEE);
    chk("t6_frz_count", fifo_count, 2);
    chk("t6_frz_dout", data_out, 8'hD0);
    cyc("t6_freeze2", 0, 1, 1, 0, 8'hEF);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        umbral_alto = 4'($urandom_range(0, 8));
        umbral_bajo = 4'($urandom_range(0, 8));
        #1;
        check_all("rnd_thr");
      end
      cyc("rnd", ($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 2) != 0,
          ($urandom % 16) == 0, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
